mcb_dat_path: RTL and testbench
===============================

Name: mcb_dat_path

Overview:
Parametrised successor to the MCB data flip-flop stage of the sdrc_lite back-end. It sits between the MCB host port and the SDR DQ pad buffers.
- Write side: buffers host words and serialises each into RATIO SDR beats with DQM derived from byte enables.
- Read side: deserialises captured SDR beats into host words and queues them behind a valid/ready handshake.
- Sticky error flags report write underflow and read overflow.

Parameters:
MCB_D_W, 32, host data width (multiple of SDR_D_W)
SDR_D_W, 16, SDR DQ width (multiple of 8)
MCB_BE_W, MCB_D_W/8, host byte-enable width
SDR_M_W, SDR_D_W/8, DQM width
WB_DEPTH, 2, write buffer depth in host words (>=1)
RB_DEPTH, 4, read buffer depth in host words (>=1)
RATIO, MCB_D_W/SDR_D_W, derived, SDR beats per host word; must be a power of 2, >=1

Ports:
mcb_clk  in  1  single clock
mcb_rst  in  1  asynchronous, active-high reset
mcb_sclr_n  in  1  synchronous clear, active-low
mcb_wvalid  in  1  host write word valid
mcb_wready  out  1  write buffer not full
mcb_wdat  in  MCB_D_W  host write data
mcb_wbe  in  MCB_BE_W  host byte enables, 1 = write byte
mcb_rvalid  out  1  read word available
mcb_rready  in  1  host accepts read word
mcb_rdat  out  MCB_D_W  read word at buffer head
d_wr_rdy  out  1  write buffer non-empty, to sequencer
d_dp_oe  in  1  sequencer: drive one write beat this cycle
d_dp_ie  in  1  sequencer: capture one read beat
dbf_dq_oe  out  1  DQ pad output enable
dbf_dq_o  out  SDR_D_W  DQ pad output data
sdr_dqm  out  SDR_M_W  DQ mask
dbf_dq_ie  out  1  DQ pad input enable
dbf_dq_i  in  SDR_D_W  DQ pad input data
err_wr_unf  out  1  sticky: write beat requested with empty buffer
err_rd_ovf  out  1  sticky: read word dropped, read buffer full

Behaviour:
- Reset values (mcb_rst high):
  - All outputs 0 except mcb_wready=1.
  - Both buffers empty; beat counters wcnt and rcnt = 0.
- mcb_sclr_n low at a clock edge:
  - Same state as reset.
  - Overrides every other event that cycle.
- Reset or clear mid-burst: partial words are discarded; the next transfer starts at beat 0.
- Write buffer:
  - FIFO of {wdat, wbe}; push on mcb_wvalid & mcb_wready.
  - mcb_wready = !full.
  - d_wr_rdy = !empty.
- Write serialiser, on a cycle with d_dp_oe=1 and buffer non-empty:
  - Next edge: dbf_dq_o = head.dat[wcnt*SDR_D_W +: SDR_D_W], sdr_dqm = ~head.be[wcnt*SDR_M_W +: SDR_M_W]. Beats are issued LSB first.
  - wcnt increments. When wcnt = RATIO-1, the head is popped and wcnt returns to 0.
- Write underflow (d_dp_oe=1, buffer empty):
  - Next edge: dbf_dq_o=0, sdr_dqm all-ones, err_wr_unf=1.
  - wcnt is unchanged.
  - There is no same-cycle bypass from a push into the serialiser.
- d_dp_oe=0: dbf_dq_o holds its value; sdr_dqm=0 next edge, so reads are unmasked.
- Output timing: dbf_dq_oe = d_dp_oe delayed 1 cycle; dbf_dq_ie = d_dp_ie delayed 1 cycle.
- Read deserialiser:
  - On each cycle with dbf_dq_ie=1, dbf_dq_i is stored to slot rcnt and rcnt increments.
  - When rcnt = RATIO-1, the assembled word (including this beat) is pushed to the read buffer and rcnt returns to 0.
- Read buffer:
  - mcb_rvalid = !empty; mcb_rdat = head, read combinationally from storage.
  - Pop on mcb_rvalid & mcb_rready.
  - Push into a full buffer with a pop in the same cycle is accepted.
  - Push into a full buffer without a pop: the word is dropped and err_rd_ovf=1.
- Error flags stay set until mcb_rst or mcb_sclr_n.
- RATIO=1: counters are degenerate; every beat is one word.

Optional Feature:
MCB_DAT_OREG_EN:
- Defined: adds one extra register stage on dbf_dq_o, dbf_dq_oe and sdr_dqm. Write latency becomes 2 cycles from d_dp_oe. dbf_dq_ie and the read path are unchanged.
- Undefined: write latency is 1 cycle, as described above.

Decomposition:
- Package mcb_dat_pkg holds:
  - default widths and depths
  - RATIO derivation function and $clog2-based counter widths
  - DQM all-ones constant
- Sub-module mcb_dat_fifo: generic synchronous FIFO (width and depth parameters, full/empty, combinational head). Instantiated twice: once as the write buffer, once as the read buffer.

Test Plan:
1. Write (32/16): push 0xAAAA5555 with be=4'b1101, then d_dp_oe for 2 cycles -> beat 0: dbf_dq_o=0x5555, sdr_dqm=2'b10; beat 1: dbf_dq_o=0xAAAA, sdr_dqm=2'b00; dbf_dq_oe high one cycle after each d_dp_oe; d_wr_rdy=0 afterwards.
2. d_dp_oe with empty write buffer -> sdr_dqm=2'b11, dbf_dq_o=0, err_wr_unf=1; flag persists until a mcb_sclr_n pulse clears it.
3. d_dp_ie for 2 cycles, with dbf_dq_i=0x1234 then 0xABCD on the dbf_dq_ie cycles -> mcb_rvalid=1, mcb_rdat=0xABCD1234; popped on mcb_rready.
4. mcb_rready=0, 5 words captured -> first 4 read back in order, err_rd_ovf=1; repeat with mcb_rready=1 on the 5th push -> no overflow.
5. Three back-to-back mcb_wvalid words with no drain -> mcb_wready low after 2; drain one word with 2 beats -> third word accepted; output data order preserved.
6. mcb_rst pulse after beat 0 of a write and beat 0 of a read -> all outputs at reset values; a new word serialises from beat 0 and a new read assembles from slot 0.

Source files
------------

// File: rtl/mcb_dat_pkg.sv
// Shared defaults and width helpers for the MCB <-> SDR data path.
// RATIO (host word / SDR beat) must be a power of 2.
package mcb_dat_pkg;

  localparam int MCB_D_W_DEF  = 32;
  localparam int SDR_D_W_DEF  = 16;
  localparam int WB_DEPTH_DEF = 2;
  localparam int RB_DEPTH_DEF = 4;

  // Wide enough for any DQM width; callers slice to SDR_M_W.
  localparam logic [63:0] DQM_ONES = '1;

  function automatic int calc_ratio(input int mcb_w, input int sdr_w);
    return mcb_w / sdr_w;
  endfunction

  // Beat counter width; kept at 1 bit when RATIO=1 so the counter still exists.
  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/mcb_dat_fifo.sv
// Generic synchronous FIFO with combinational head (zero when empty).
// A push into a full FIFO is taken only if a pop happens in the same cycle.
module mcb_dat_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_sclr_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dat   = o_empty ? '0 : r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (!i_sclr_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

endmodule

// File: rtl/mcb_dat_path.sv
// MCB host port <-> SDR DQ pads: write serialiser with DQM, read deserialiser, sticky errors.
// Define MCB_DAT_OREG_EN to add an output register on dbf_dq_o/dbf_dq_oe/sdr_dqm.
module mcb_dat_path
  import mcb_dat_pkg::*;
#(
  parameter int MCB_D_W  = MCB_D_W_DEF,
  parameter int SDR_D_W  = SDR_D_W_DEF,
  parameter int MCB_BE_W = MCB_D_W / 8,
  parameter int SDR_M_W  = SDR_D_W / 8,
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int RB_DEPTH = RB_DEPTH_DEF
) (
  input  logic                mcb_clk,
  input  logic                mcb_rst,
  input  logic                mcb_sclr_n,
  input  logic                mcb_wvalid,
  output logic                mcb_wready,
  input  logic [MCB_D_W-1:0]  mcb_wdat,
  input  logic [MCB_BE_W-1:0] mcb_wbe,
  output logic                mcb_rvalid,
  input  logic                mcb_rready,
  output logic [MCB_D_W-1:0]  mcb_rdat,
  output logic                d_wr_rdy,
  input  logic                d_dp_oe,
  input  logic                d_dp_ie,
  output logic                dbf_dq_oe,
  output logic [SDR_D_W-1:0]  dbf_dq_o,
  output logic [SDR_M_W-1:0]  sdr_dqm,
  output logic                dbf_dq_ie,
  input  logic [SDR_D_W-1:0]  dbf_dq_i,
  output logic                err_wr_unf,
  output logic                err_rd_ovf
);

  localparam int RATIO = calc_ratio(MCB_D_W, SDR_D_W);
  localparam int CNT_W = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [MCB_D_W+MCB_BE_W-1:0] w_wb_head;
  logic [MCB_D_W-1:0]          w_head_dat;
  logic [MCB_BE_W-1:0]         w_head_be;
  logic                        w_wb_full;
  logic                        w_wb_empty;
  logic                        w_wb_pop;
  logic                        w_rb_full;
  logic                        w_rb_empty;
  logic                        w_rb_req;
  logic [MCB_D_W-1:0]          w_rword;

  logic [CNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]   r_rcnt;
  logic [SDR_D_W-1:0] r_dq_o;
  logic [SDR_M_W-1:0] r_dqm;
  logic               r_dq_oe;
  logic               r_dq_ie;
  logic               r_err_unf;
  logic               r_err_ovf;
  logic [SDR_D_W-1:0] r_rslot [RATIO];

  assign w_head_dat = w_wb_head[MCB_BE_W +: MCB_D_W];
  assign w_head_be  = w_wb_head[MCB_BE_W-1:0];
  assign w_wb_pop   = d_dp_oe & ~w_wb_empty & (r_wcnt == LAST);
  assign w_rb_req   = r_dq_ie & (r_rcnt == LAST);

  assign mcb_wready = ~w_wb_full;
  assign d_wr_rdy   = ~w_wb_empty;
  assign mcb_rvalid = ~w_rb_empty;
  assign dbf_dq_ie  = r_dq_ie;
  assign err_wr_unf = r_err_unf;
  assign err_rd_ovf = r_err_ovf;

  mcb_dat_fifo #(.W(MCB_D_W + MCB_BE_W), .DEPTH(WB_DEPTH)) u_wbuf (
    .i_clk    (mcb_clk),
    .i_rst    (mcb_rst),
    .i_sclr_n (mcb_sclr_n),
    .i_push   (mcb_wvalid & ~w_wb_full),
    .i_dat    ({mcb_wdat, mcb_wbe}),
    .i_pop    (w_wb_pop),
    .o_dat    (w_wb_head),
    .o_full   (w_wb_full),
    .o_empty  (w_wb_empty)
  );

  mcb_dat_fifo #(.W(MCB_D_W), .DEPTH(RB_DEPTH)) u_rbuf (
    .i_clk    (mcb_clk),
    .i_rst    (mcb_rst),
    .i_sclr_n (mcb_sclr_n),
    .i_push   (w_rb_req),
    .i_dat    (w_rword),
    .i_pop    (mcb_rready),
    .o_dat    (mcb_rdat),
    .o_full   (w_rb_full),
    .o_empty  (w_rb_empty)
  );

  // The current beat goes straight into its slot of the assembled word.
  always_comb begin
    w_rword = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_rword[i*SDR_D_W +: SDR_D_W] = (CNT_W'(i) == r_rcnt) ? dbf_dq_i : r_rslot[i];
    end
  end

  always_ff @(posedge mcb_clk) begin
    if (r_dq_ie) r_rslot[r_rcnt] <= dbf_dq_i;
  end

  always_ff @(posedge mcb_clk or posedge mcb_rst) begin
    if (mcb_rst) begin
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_dq_o    <= '0;
      r_dqm     <= '0;
      r_dq_oe   <= 1'b0;
      r_dq_ie   <= 1'b0;
      r_err_unf <= 1'b0;
      r_err_ovf <= 1'b0;
    end else if (!mcb_sclr_n) begin
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_dq_o    <= '0;
      r_dqm     <= '0;
      r_dq_oe   <= 1'b0;
      r_dq_ie   <= 1'b0;
      r_err_unf <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_dq_oe <= d_dp_oe;
      r_dq_ie <= d_dp_ie;
      if (d_dp_oe) begin
        if (!w_wb_empty) begin
          r_dq_o <= w_head_dat[r_wcnt*SDR_D_W +: SDR_D_W];
          r_dqm  <= ~w_head_be[r_wcnt*SDR_M_W +: SDR_M_W];
          r_wcnt <= (r_wcnt == LAST) ? '0 : r_wcnt + 1'b1;
        end else begin
          r_dq_o    <= '0;
          r_dqm     <= DQM_ONES[SDR_M_W-1:0];
          r_err_unf <= 1'b1;
        end
      end else begin
        r_dqm <= '0;
      end
      if (r_dq_ie) r_rcnt <= (r_rcnt == LAST) ? '0 : r_rcnt + 1'b1;
      // A full read buffer only takes the word if the host pops this cycle.
      if (w_rb_req && w_rb_full && !mcb_rready) r_err_ovf <= 1'b1;
    end
  end

`ifdef MCB_DAT_OREG_EN
  logic [SDR_D_W-1:0] r_dq_o_q;
  logic [SDR_M_W-1:0] r_dqm_q;
  logic               r_dq_oe_q;

  always_ff @(posedge mcb_clk or posedge mcb_rst) begin
    if (mcb_rst) begin
      r_dq_o_q  <= '0;
      r_dqm_q   <= '0;
      r_dq_oe_q <= 1'b0;
    end else if (!mcb_sclr_n) begin
      r_dq_o_q  <= '0;
      r_dqm_q   <= '0;
      r_dq_oe_q <= 1'b0;
    end else begin
      r_dq_o_q  <= r_dq_o;
      r_dqm_q   <= r_dqm;
      r_dq_oe_q <= r_dq_oe;
    end
  end

  assign dbf_dq_o  = r_dq_o_q;
  assign sdr_dqm   = r_dqm_q;
  assign dbf_dq_oe = r_dq_oe_q;
`else
  assign dbf_dq_o  = r_dq_o;
  assign sdr_dqm   = r_dqm;
  assign dbf_dq_oe = r_dq_oe;
`endif

endmodule

// File: tb/tb_mcb_dat_path.sv
// Directed bench for mcb_dat_path at default widths (32/16, WB 2, RB 4), default build.
module tb_mcb_dat_path;

  logic        mcb_clk = 1'b0;
  logic        mcb_rst;
  logic        mcb_sclr_n;
  logic        mcb_wvalid;
  logic        mcb_wready;
  logic [31:0] mcb_wdat;
  logic [3:0]  mcb_wbe;
  logic        mcb_rvalid;
  logic        mcb_rready;
  logic [31:0] mcb_rdat;
  logic        d_wr_rdy;
  logic        d_dp_oe;
  logic        d_dp_ie;
  logic        dbf_dq_oe;
  logic [15:0] dbf_dq_o;
  logic [1:0]  sdr_dqm;
  logic        dbf_dq_ie;
  logic [15:0] dbf_dq_i;
  logic        err_wr_unf;
  logic        err_rd_ovf;

  int total = 0;
  int bad   = 0;

  always #5 mcb_clk = ~mcb_clk;

  mcb_dat_path dut (
    .mcb_clk    (mcb_clk),
    .mcb_rst    (mcb_rst),
    .mcb_sclr_n (mcb_sclr_n),
    .mcb_wvalid (mcb_wvalid),
    .mcb_wready (mcb_wready),
    .mcb_wdat   (mcb_wdat),
    .mcb_wbe    (mcb_wbe),
    .mcb_rvalid (mcb_rvalid),
    .mcb_rready (mcb_rready),
    .mcb_rdat   (mcb_rdat),
    .d_wr_rdy   (d_wr_rdy),
    .d_dp_oe    (d_dp_oe),
    .d_dp_ie    (d_dp_ie),
    .dbf_dq_oe  (dbf_dq_oe),
    .dbf_dq_o   (dbf_dq_o),
    .sdr_dqm    (sdr_dqm),
    .dbf_dq_ie  (dbf_dq_ie),
    .dbf_dq_i   (dbf_dq_i),
    .err_wr_unf (err_wr_unf),
    .err_rd_ovf (err_rd_ovf)
  );

  task automatic tick;
    @(posedge mcb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".wready"}, mcb_wready, 1);
    chk({tag, ".wr_rdy"}, d_wr_rdy, 0);
    chk({tag, ".rvalid"}, mcb_rvalid, 0);
    chk({tag, ".rdat"}, mcb_rdat, 0);
    chk({tag, ".dq_oe"}, dbf_dq_oe, 0);
    chk({tag, ".dq_o"}, dbf_dq_o, 0);
    chk({tag, ".dqm"}, sdr_dqm, 0);
    chk({tag, ".dq_ie"}, dbf_dq_ie, 0);
    chk({tag, ".err_unf"}, err_wr_unf, 0);
    chk({tag, ".err_ovf"}, err_rd_ovf, 0);
  endtask

  // Two-beat capture: low half on the first dbf_dq_ie cycle, high half on the second.
  task automatic read_word(input logic [31:0] w, input logic rdy_last);
    d_dp_ie = 1'b1;
    tick();
    dbf_dq_i = w[15:0];
    tick();
    d_dp_ie  = 1'b0;
    dbf_dq_i = w[31:16];
    mcb_rready = rdy_last;
    tick();
    mcb_rready = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [31:0] exp);
    chk({tag, ".rvalid"}, mcb_rvalid, 1);
    chk({tag, ".rdat"}, mcb_rdat, exp);
    mcb_rready = 1'b1;
    tick();
    mcb_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] w4 [5];
    w4[0] = 32'h1111_0000; w4[1] = 32'h2222_0001; w4[2] = 32'h3333_0002;
    w4[3] = 32'h4444_0003; w4[4] = 32'h5555_0004;

    mcb_rst = 1'b1; mcb_sclr_n = 1'b1; mcb_wvalid = 1'b0; mcb_wdat = '0; mcb_wbe = '0;
    mcb_rready = 1'b0; d_dp_oe = 1'b0; d_dp_ie = 1'b0; dbf_dq_i = '0;
    tick(); tick();
    chk_idle_outputs("reset");
    mcb_rst = 1'b0;
    tick();

    // 1: single word serialised LSB beat first
    mcb_wvalid = 1'b1; mcb_wdat = 32'hAAAA_5555; mcb_wbe = 4'b1101;
    tick();
    mcb_wvalid = 1'b0;
    chk("t1.wr_rdy", d_wr_rdy, 1);
    d_dp_oe = 1'b1;
    tick();
    chk("t1.b0.dq_o", dbf_dq_o, 16'h5555);
    chk("t1.b0.dqm", sdr_dqm, 2'b10);
    chk("t1.b0.oe", dbf_dq_oe, 1);
    tick();
    d_dp_oe = 1'b0;
    chk("t1.b1.dq_o", dbf_dq_o, 16'hAAAA);
    chk("t1.b1.dqm", sdr_dqm, 2'b00);
    chk("t1.b1.oe", dbf_dq_oe, 1);
    chk("t1.wr_rdy_after", d_wr_rdy, 0);
    tick();
    chk("t1.idle.oe", dbf_dq_oe, 0);
    chk("t1.idle.dq_hold", dbf_dq_o, 16'hAAAA);
    chk("t1.idle.dqm", sdr_dqm, 2'b00);

    // 2: underflow
    d_dp_oe = 1'b1;
    tick();
    d_dp_oe = 1'b0;
    chk("t2.dqm", sdr_dqm, 2'b11);
    chk("t2.dq_o", dbf_dq_o, 0);
    chk("t2.err", err_wr_unf, 1);
    tick(); tick();
    chk("t2.err_sticky", err_wr_unf, 1);
    chk("t2.dqm_idle", sdr_dqm, 2'b00);
    mcb_sclr_n = 1'b0;
    tick();
    mcb_sclr_n = 1'b1;
    chk("t2.err_clr", err_wr_unf, 0);
    chk("t2.wready_clr", mcb_wready, 1);

    // 3: one word read back
    d_dp_ie = 1'b1;
    tick();
    chk("t3.dq_ie", dbf_dq_ie, 1);
    dbf_dq_i = 16'h1234;
    tick();
    chk("t3.not_yet", mcb_rvalid, 0);
    d_dp_ie = 1'b0; dbf_dq_i = 16'hABCD;
    tick();
    pop_word("t3", 32'hABCD_1234);
    chk("t3.empty", mcb_rvalid, 0);

    // 4: overflow with no pop, then the same fill with a pop on the fifth push
    for (int i = 0; i < 5; i++) read_word(w4[i], 1'b0);
    chk("t4.ovf", err_rd_ovf, 1);
    for (int i = 0; i < 4; i++) pop_word($sformatf("t4.rd%0d", i), w4[i]);
    chk("t4.empty", mcb_rvalid, 0);
    mcb_sclr_n = 1'b0;
    tick();
    mcb_sclr_n = 1'b1;
    chk("t4.ovf_clr", err_rd_ovf, 0);
    for (int i = 0; i < 4; i++) read_word(w4[i], 1'b0);
    read_word(w4[4], 1'b1);
    chk("t4.no_ovf", err_rd_ovf, 0);
    for (int i = 1; i < 5; i++) pop_word($sformatf("t4b.rd%0d", i), w4[i]);

    // 5: write buffer fills after two words, drains in order
    mcb_wbe = 4'hF;
    mcb_wvalid = 1'b1; mcb_wdat = 32'h1111_2222;
    tick();
    mcb_wdat = 32'h3333_4444;
    tick();
    chk("t5.full", mcb_wready, 0);
    mcb_wdat = 32'h5555_6666;
    tick();
    chk("t5.still_full", mcb_wready, 0);
    d_dp_oe = 1'b1;
    tick();
    chk("t5.w0.b0", dbf_dq_o, 16'h2222);
    tick();
    chk("t5.w0.b1", dbf_dq_o, 16'h1111);
    chk("t5.ready_again", mcb_wready, 1);
    tick();
    mcb_wvalid = 1'b0;
    chk("t5.w1.b0", dbf_dq_o, 16'h4444);
    tick();
    chk("t5.w1.b1", dbf_dq_o, 16'h3333);
    tick();
    chk("t5.w2.b0", dbf_dq_o, 16'h6666);
    tick();
    d_dp_oe = 1'b0;
    chk("t5.w2.b1", dbf_dq_o, 16'h5555);
    chk("t5.dqm", sdr_dqm, 2'b00);
    chk("t5.drained", d_wr_rdy, 0);
    chk("t5.no_unf", err_wr_unf, 0);

    // 6: reset mid-burst on both sides
    mcb_wvalid = 1'b1; mcb_wdat = 32'hCAFE_BEEF;
    tick();
    mcb_wvalid = 1'b0; d_dp_oe = 1'b1;
    tick();
    d_dp_oe = 1'b0;
    chk("t6.pre.b0", dbf_dq_o, 16'hBEEF);
    d_dp_ie = 1'b1;
    tick();
    d_dp_ie = 1'b0; dbf_dq_i = 16'h1111;
    tick();
    mcb_rst = 1'b1;
    #2;
    chk_idle_outputs("t6.rst");
    mcb_rst = 1'b0;
    tick();
    mcb_wvalid = 1'b1; mcb_wdat = 32'h8765_4321; mcb_wbe = 4'b1100;
    tick();
    mcb_wvalid = 1'b0; d_dp_oe = 1'b1;
    tick();
    chk("t6.b0.dq_o", dbf_dq_o, 16'h4321);
    chk("t6.b0.dqm", sdr_dqm, 2'b11);
    tick();
    d_dp_oe = 1'b0;
    chk("t6.b1.dq_o", dbf_dq_o, 16'h8765);
    chk("t6.b1.dqm", sdr_dqm, 2'b00);
    chk("t6.wr_rdy", d_wr_rdy, 0);
    read_word(32'h0F0E_0D0C, 1'b0);
    pop_word("t6.rd", 32'h0F0E_0D0C);
    chk("t6.empty", mcb_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
